// File: rtl/mem_latency_model_if.sv
// ---------------------------------------------------------------------------
// mem_latency_model_if
// Request/response bundle between a requester (CPU, cache or testbench) and
// the mem_latency_model word memory.
//
// Signals:
//   offset      byte base address of the memory window (hold stable while busy)
//   req_valid   request strobe, held until mem_ready is seen
//   req_wen     1 = write, 0 = read
//   req_addr    byte address, bits [1:0] ignored
//   req_wdata   write data
//   req_be      per-byte write enables (only when MEM_BYTE_EN_EN is defined)
//   mem_ready   one-cycle completion pulse
//   mem_rdata   read data, valid while mem_ready is high, held afterwards
//   addr_err    pulses with mem_ready when the access missed the window
//   busy        high from acceptance until the completion cycle ends
//
// Modports: master drives requests, slave is the memory.
// Optional macro: MEM_BYTE_EN_EN adds req_be.
// ---------------------------------------------------------------------------
interface mem_latency_model_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   offset;
    logic                req_valid;
    logic                req_wen;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
`ifdef MEM_BYTE_EN_EN
    logic [DATA_W/8-1:0] req_be;
`endif
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic                addr_err;
    logic                busy;

    modport master (
        output offset, req_valid, req_wen, req_addr, req_wdata,
`ifdef MEM_BYTE_EN_EN
        output req_be,
`endif
        input  mem_ready, mem_rdata, addr_err, busy
    );

    modport slave (
        input  offset, req_valid, req_wen, req_addr, req_wdata,
`ifdef MEM_BYTE_EN_EN
        input  req_be,
`endif
        output mem_ready, mem_rdata, addr_err, busy
    );
endinterface

// File: rtl/mem_latency_model.sv
// ---------------------------------------------------------------------------
// mem_latency_model
// Word memory with a request/ready handshake and a fixed, programmable access
// latency. Accesses outside the [offset, offset + 4*WORD_DEPTH) window are
// completed with addr_err and have no effect on the contents.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears state, outputs and contents
//   bus    mem_latency_model_if.slave (request inputs, registered outputs)
//
// Optional macro: MEM_BYTE_EN_EN -- byte-lane write enables via bus.req_be.
//
// state | meaning
// IDLE  | waiting for req_valid; request fields sampled only here
// BUSY  | latency countdown; access performed when the counter hits 0
// DONE  | mem_ready/addr_err pulse cycle; back to IDLE on the next edge
// ---------------------------------------------------------------------------
module mem_latency_model #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int WORD_DEPTH = 36,
    parameter int LATENCY    = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_latency_model_if.slave  bus
);
    localparam int IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                wen_q;
    logic                hit_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
`ifdef MEM_BYTE_EN_EN
    logic [BE_W-1:0]     be_q;
`endif
    logic                ready_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                busy_q;
    logic [DATA_W-1:0]   mem_q [WORD_DEPTH];

    // Window decode is done once at acceptance; offset is stable while busy,
    // so latching the decoded index and hit flag is equivalent to latching
    // the address. The subtraction wraps, hence the explicit >= guard.
    logic [ADDR_W-1:0]   diff_d;
    logic [ADDR_W-1:0]   word_off_d;
    logic                hit_d;
    logic [IDX_W-1:0]    idx_d;

    always_comb begin
        diff_d     = bus.req_addr - bus.offset;
        word_off_d = diff_d >> 2;
        hit_d      = (bus.req_addr >= bus.offset) &&
                     (word_off_d < ADDR_W'(WORD_DEPTH));
        idx_d      = word_off_d[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef MEM_BYTE_EN_EN
            be_q    <= '0;
`endif
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < WORD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        wen_q   <= bus.req_wen;
                        hit_q   <= hit_d;
                        idx_q   <= idx_d;
                        wdata_q <= bus.req_wdata;
`ifdef MEM_BYTE_EN_EN
                        be_q    <= bus.req_be;
`endif
                        cnt_q   <= 8'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        if (hit_q) begin
                            if (wen_q) begin
`ifdef MEM_BYTE_EN_EN
                                for (int b = 0; b < BE_W; b++) begin
                                    if (be_q[b]) begin
                                        mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                                    end
                                end
`else
                                mem_q[idx_q] <= wdata_q;
`endif
                            end else begin
                                rdata_q <= mem_q[idx_q];
                            end
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.addr_err  = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_latency_model.sv
// ---------------------------------------------------------------------------
// tb_mem_latency_model
// Directed and randomized checks of mem_latency_model against a word-array
// reference model of the memory window.
// Optional macro: MEM_BYTE_EN_EN (byte-enable writes).
// ---------------------------------------------------------------------------
module tb_mem_latency_model;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 36;
    localparam int          LAT    = 4;
    localparam logic [31:0] OFS    = 32'h1001_0000;

    logic clk;
    logic rst_n;

    mem_latency_model_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_latency_model #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORD_DEPTH(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= OFS) && (((a - OFS) >> 2) < 32'(DEPTH));
    endfunction

    function automatic int win_idx(input logic [31:0] a);
        return int'((a - OFS) >> 2);
    endfunction

    // Model effect of a completed access; returns expected addr_err.
    function automatic bit model_access(input logic wen, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] mask;
        if (!in_win(a)) begin
            exp_rdata = '0;
            return 1'b1;
        end
`ifdef MEM_BYTE_EN_EN
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
`else
        mask = 32'hFFFF_FFFF;
        if (be == 4'hF) mask = 32'hFFFF_FFFF;
`endif
        if (wen) model[win_idx(a)] = (model[win_idx(a)] & ~mask) | (wd & mask);
        else     exp_rdata = model[win_idx(a)];
        return 1'b0;
    endfunction

    task automatic drive_req(input logic wen, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = a;
        bus.req_wdata = wd;
`ifdef MEM_BYTE_EN_EN
        bus.req_be    = be;
`endif
    endtask

    // Counts edges from the current sample point until mem_ready, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.mem_ready !== 1'b1 && n < LAT + 6) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_done(input string tag, input bit exp_err);
        check({tag, "_ready"}, {31'd0, bus.mem_ready}, 32'd1);
        check({tag, "_err"},   {31'd0, bus.addr_err},  {31'd0, exp_err});
        check({tag, "_rdata"}, bus.mem_rdata, exp_rdata);
        check({tag, "_busy"},  {31'd0, bus.busy},      32'd1);
        @(posedge clk); #1;
        check({tag, "_ready_drop"}, {31'd0, bus.mem_ready}, 32'd0);
        check({tag, "_err_drop"},   {31'd0, bus.addr_err},  32'd0);
        check({tag, "_busy_drop"},  {31'd0, bus.busy},      32'd0);
        check({tag, "_rdata_hold"}, bus.mem_rdata, exp_rdata);
    endtask

    // Full access with req_valid dropped and request fields scrambled after
    // acceptance, so the DUT must work from its latched copy.
    task automatic access(input string tag, input logic wen, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        int n;
        bit e_err;
        drive_req(wen, a, wd, be);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wen   = ~wen;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
`ifdef MEM_BYTE_EN_EN
        bus.req_be    = 4'($urandom);
`endif
        check({tag, "_busy_acc"}, {31'd0, bus.busy}, 32'd1);
        wait_ready(n);
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        e_err = model_access(wen, a, wd, be);
        check_done(tag, e_err);
    endtask

    initial begin
        int n;
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        wen;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_rdata     = '0;
        rst_n         = 1'b0;
        bus.offset    = OFS;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef MEM_BYTE_EN_EN
        bus.req_be    = 4'hF;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        check("rst_err",   {31'd0, bus.addr_err}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        access("rd_base0", 1'b0, OFS, 32'h0, 4'hF);

        access("wr_beef", 1'b1, OFS + 32'h8, 32'hDEAD_BEEF, 4'hF);
        access("rd_beef", 1'b0, OFS + 32'h8, 32'h0, 4'hF);
        check("rd_beef_val", bus.mem_rdata, 32'hDEAD_BEEF);

        access("wr_top",  1'b1, OFS + 32'h8C, 32'hCAFE_0035, 4'hF);
        access("rd_top",  1'b0, OFS + 32'h8C, 32'h0, 4'hF);
        access("wr_past", 1'b1, OFS + 32'h90, 32'h1111_1111, 4'hF);
        access("wr_below",1'b1, OFS - 32'h4,  32'h2222_2222, 4'hF);
        access("rd_top2", 1'b0, OFS + 32'h8C, 32'h0, 4'hF);
        access("rd_zero", 1'b0, OFS, 32'h0, 4'hF);

`ifdef MEM_BYTE_EN_EN
        access("be_init", 1'b1, OFS + 32'h20, 32'h1122_3344, 4'hF);
        access("be_wr",   1'b1, OFS + 32'h20, 32'hAABB_CCDD, 4'b0101);
        access("be_rd",   1'b0, OFS + 32'h20, 32'h0, 4'hF);
        check("be_merge", bus.mem_rdata, 32'h11BB_33DD);
`endif

        // Held request: address changed during BUSY, valid kept high through
        // DONE; re-acceptance must come exactly one edge after the DONE cycle.
        access("h_init5", 1'b1, OFS + 32'h14, 32'h5555_A5A5, 4'hF);
        access("h_init7", 1'b1, OFS + 32'h1C, 32'h7777_7A7A, 4'hF);
        drive_req(1'b0, OFS + 32'h14, 32'h0, 4'hF);
        @(posedge clk); #1;
        bus.req_addr = OFS + 32'h1C;
        wait_ready(n);
        check("held_lat", 32'(n), 32'(LAT));
        check("held_rdA", bus.mem_rdata, 32'h5555_A5A5);
        @(posedge clk); #1;
        check("held_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        check("held_reacc_busy", {31'd0, bus.busy}, 32'd1);
        bus.req_valid = 1'b0;
        wait_ready(n);
        check("held_lat2", 32'(n), 32'(LAT));
        check("held_rdB", bus.mem_rdata, 32'h7777_7A7A);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 5))
                0, 1: a = OFS + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
                2:    a = OFS + 32'h8C;
                3:    a = OFS + 32'(4 * $urandom_range(DEPTH, DEPTH + 4));
                4:    a = OFS - 32'(4 * $urandom_range(1, 4));
                default: a = $urandom;
            endcase
            wen = 1'($urandom);
            wd  = $urandom;
            be  = 4'($urandom);
`ifndef MEM_BYTE_EN_EN
            be  = 4'hF;
`endif
            access("rnd", wen, a, wd, be);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Abort: reset two cycles into a write; the write must not land.
        drive_req(1'b1, OFS + 32'h4, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("abort_rdata", bus.mem_rdata, 32'd0);
        check("abort_err",   {31'd0, bus.addr_err}, 32'd0);
        check("abort_busy",  {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_rdata = '0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("abort_noready", {31'd0, bus.mem_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access("post_rd4", 1'b0, OFS + 32'h4, 32'h0, 4'hF);
        access("post_rd8", 1'b0, OFS + 32'h8, 32'h0, 4'hF);
        access("post_rd0", 1'b0, OFS, 32'h0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
